// File: rtl/instruction_encoder_if.sv
// Field-set input handshake and instruction-memory write port of instruction_encoder.
// master = encoder side, slave = loader/memory side.
interface instruction_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [7:0]        in_dest;
    logic [7:0]        in_src1;
    logic [7:0]        in_src2;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writedata;
    logic              mem_busywait;

    modport master (
        input  in_valid, in_opcode, in_dest, in_src1, in_src2, mem_busywait,
        output in_ready, mem_write, mem_address, mem_writedata
    );

    modport slave (
        output in_valid, in_opcode, in_dest, in_src1, in_src2, mem_busywait,
        input  in_ready, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs instruction fields into 32-bit words, buffers them and writes them to instruction memory.
// Optional INSTR_ENCODER_CHECK_EN: drop opcodes above 0x0D at acceptance and raise sticky err.
module instruction_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_encoder_if.master bus,
    input  logic                  base_load,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic [15:0]           count,
    output logic                  err,
    output logic                  idle
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            state, state_nx;
    logic [31:0]       fifo [DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              full, empty, push, pop, legal, accept;
    logic [ADDR_W-1:0] addr;

    // Register fields keep only bits [2:0]; offsets/immediates pass whole.
    function automatic logic [31:0] encode(input logic [7:0] op, input logic [7:0] d,
                                           input logic [7:0] s1, input logic [7:0] s2);
        logic [7:0] dr, r1, r2;
        dr = {5'b0, d[2:0]};
        r1 = {5'b0, s1[2:0]};
        r2 = {5'b0, s2[2:0]};
        case (op)
            8'h00:                             encode = {op, dr, 8'h00, s2};
            8'h05:                             encode = {op, dr, 8'h00, r2};
            8'h01, 8'h02, 8'h03, 8'h04, 8'h09: encode = {op, dr, r1, r2};
            8'h06:                             encode = {op, d, 8'h00, 8'h00};
            8'h07, 8'h08:                      encode = {op, d, r1, r2};
            8'h0A, 8'h0B, 8'h0C, 8'h0D:        encode = {op, dr, r1, s2};
            default:                           encode = {op, d, s1, s2};
        endcase
    endfunction

`ifdef INSTR_ENCODER_CHECK_EN
    assign legal = (bus.in_opcode <= 8'h0D);
`else
    assign legal = 1'b1;
`endif

    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal;

    assign bus.in_ready      = !full;
    assign bus.mem_write     = (state == S_WRITE);
    assign bus.mem_address   = addr;
    assign bus.mem_writedata = empty ? 32'h0 : fifo[rd_ptr[PW-1:0]];
    assign idle              = empty && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[PW-1:0]] <= encode(bus.in_opcode, bus.in_dest, bus.in_src1, bus.in_src2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE:  if (!empty) state_nx = S_WRITE;
            S_WRITE: if (!bus.mem_busywait) begin
                pop      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A completed write and a base load never coincide: base load needs idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                addr  <= addr + ADDR_W'(4);
                count <= count + 16'd1;
            end else if (base_load && idle) begin
                addr <= base_addr;
            end
        end
    end

`ifdef INSTR_ENCODER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err <= 1'b0;
        else if (accept && !legal) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Reverse of the simple processor's opcode decoder. Accepts instruction fields (opcode, destination/offset, source 1, source 2/immediate), packs them into the 32-bit instruction word the processor fetches, buffers the words in a small FIFO and writes them sequentially into instruction memory over the memory write/busywait handshake. Sits between the test or boot loader and instruction memory.

## Interface
- ADDR_W, 10, instruction memory byte-address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- IN_VALID  input  1  field set presented
- IN_READY  output  1  encoder can accept (FIFO not full)
- IN_OPCODE  input  8  opcode
- IN_DEST  input  8  destination register or branch/jump offset
- IN_SRC1  input  8  source register 1
- IN_SRC2  input  8  source register 2 or immediate
- BASE_LOAD  input  1  load write address from BASE_ADDR
- BASE_ADDR  input  ADDR_W  start byte address
- MEM_WRITE  output  1  memory write request
- MEM_ADDRESS  output  ADDR_W  byte address of current word
- MEM_WRITEDATA  output  32  encoded instruction
- MEM_BUSYWAIT  input  1  memory stall
- COUNT  output  16  words written since reset
- ERR  output  1  sticky illegal-opcode flag
- IDLE  output  1  FIFO empty and FSM in IDLE

## Operation
- Word layout: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm. Register fields use bits [2:0] only, upper bits forced 0; unused fields 0.
- 0x00 loadi: dest reg, src1=0, src2 full 8-bit immediate.
- 0x05 mov: dest reg, src1=0, src2 reg.
- 0x01 add, 0x02 and, 0x03 or, 0x04 sub, 0x09 mult: dest, src1, src2 all regs.
- 0x06 j: dest full 8-bit offset, src1=0, src2=0.
- 0x07 beq, 0x08 bne: dest full 8-bit offset, src1 reg, src2 reg.
- 0x0A sll, 0x0B srl, 0x0C sra, 0x0D ror: dest reg, src1 reg, src2 full 8-bit shift amount.
- Handshake: field set accepted on rising edge with IN_VALID=1 and IN_READY=1; encoded word pushed into FIFO that edge. IN_READY = !full; a pop in the same cycle does not open a slot when full.
- Write FSM, states IDLE, WRITE. IDLE→WRITE when FIFO non-empty. In WRITE: MEM_WRITE=1, MEM_WRITEDATA = FIFO head, MEM_ADDRESS = address register. Edge with MEM_BUSYWAIT=0 completes the write: pop, address += 4 (wraps modulo 2^ADDR_W), COUNT += 1 (wraps at 16 bits), →IDLE. MEM_WRITE is therefore low ≥1 cycle between writes.
- BASE_LOAD honoured only when IDLE=1; ignored otherwise. Address register resets to 0.
- Reset mid-write: FIFO emptied, FSM to IDLE, MEM_WRITE drops immediately (asynchronous); the partial write is abandoned.

## Timing
- Reset values: IN_READY=1, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0 (empty head), COUNT=0, ERR=0, IDLE=1.
- Field accepted at edge N into empty FIFO: MEM_WRITE high after edge N+1.
- With zero busywait: one word per 2 cycles; full FIFO of DEPTH drains in 2·DEPTH cycles.
- MEM_WRITEDATA and MEM_ADDRESS stable throughout WRITE state.

## Configuration
- INSTR_ENCODER_CHECK_EN defined: opcodes above 0x0D are dropped at acceptance (still handshaken, IN_READY unaffected, not pushed) and ERR sets, sticky until reset.
- Not defined: every opcode accepted; unknown opcodes encoded with all three fields passed full 8-bit; ERR tied 0.

## Test plan
- Reset, push loadi dest=0x0B src2=0xFF, no busywait -> MEM_WRITE at cycle 2, MEM_WRITEDATA=0x000300FF, MEM_ADDRESS=0, COUNT=1.
- Push add 1,2,3 then beq off=0xFE,4,5 with busywait held 3 cycles per write -> words 0x01010203 at 0x000 and 0x07FE0405 at 0x004, data stable during stall.
- Push 6 words with memory busy -> IN_READY=0 after 4 accepted, IN_VALID held; all 6 written in order, addresses 0x00..0x14.
- BASE_LOAD 0x3FC while idle, push two j off=0x10 -> writes at 0x3FC then 0x000 (wrap), data 0x06100000.
- With INSTR_ENCODER_CHECK_EN, push opcode 0x20 then sll 1,2,imm=3 -> ERR=1, only 0x0A010203 written, COUNT=1.
- Assert RESET during WRITE with busywait high -> MEM_WRITE=0 at once, IDLE=1, COUNT=0, FIFO empty.
